// File: rtl/line_steer_pwm.sv
// PD line-steering controller with double-buffered left/right PWM outputs and a lost-line FSM.
// Optional deadband on the centroid error is enabled by defining STEER_DEADBAND_EN.
module line_steer_pwm #(
  parameter int IMG_W        = 640,
  parameter int PWM_BITS     = 8,
  parameter int BASE_DUTY    = 128,
  parameter int KP           = 4,
  parameter int KD           = 2,
  parameter int SHIFT        = 2,
  parameter int LOST_HOLD    = 4,
  parameter int SEARCH_TICKS = 64,
  parameter int SEARCH_DUTY  = 96,
  parameter int DEADBAND     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [10:0]         centroid_x,
  input  logic                line_valid,
  input  logic                line_lost,
  output logic                pwm_left,
  output logic                pwm_right,
  output logic [PWM_BITS-1:0] duty_left,
  output logic [PWM_BITS-1:0] duty_right,
  output logic [1:0]          steer_state,
  output logic                ctrl_tick
);

  localparam int CW = 16;
  localparam int AW = PWM_BITS + 2;

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_COAST  = 2'd2;
  localparam logic [1:0] ST_SEARCH = 2'd3;

`ifdef STEER_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  localparam logic [PWM_BITS-1:0] DMAX_V         = '1;
  localparam logic signed [11:0]  CENTER_V       = 12'(IMG_W / 2);
  localparam logic [11:0]         DEADBAND_V     = 12'(DEADBAND);
  localparam logic signed [23:0]  KP_V           = 24'(KP);
  localparam logic signed [23:0]  KD_V           = 24'(KD);
  localparam logic signed [23:0]  SAT_HI         = 24'((1 << PWM_BITS) - 1);
  localparam logic signed [23:0]  SAT_LO         = -SAT_HI;
  localparam logic signed [AW-1:0] DMAX_A        = AW'((1 << PWM_BITS) - 1);
  localparam logic signed [AW-1:0] BASE_V        = AW'(BASE_DUTY);
  localparam logic [PWM_BITS-1:0] SEARCH_V       = PWM_BITS'(SEARCH_DUTY);
  localparam logic [CW-1:0]       LOST_HOLD_V    = CW'(LOST_HOLD);
  localparam logic [CW-1:0]       SEARCH_TICKS_V = CW'(SEARCH_TICKS);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       search_q, search_d;
  logic signed [11:0]  prev_err_q, prev_err_d;
  logic                s1_vld_q, s1_vld_d;
  logic [1:0]          s1_mode_q, s1_mode_d;
  logic signed [11:0]  err_q, err_d;
  logic signed [12:0]  derr_q, derr_d;
  logic                s2_vld_q, s2_vld_d;
  logic [1:0]          s2_mode_q, s2_mode_d;
  logic signed [23:0]  kp_term_q, kp_term_d;
  logic signed [23:0]  kd_term_q, kd_term_d;
  logic [PWM_BITS-1:0] pend_l_q, pend_l_d;
  logic [PWM_BITS-1:0] pend_r_q, pend_r_d;
  logic [PWM_BITS-1:0] duty_l_q, duty_l_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;

  logic               tick;
  logic               found;
  logic signed [11:0] err_raw;
  logic [11:0]        err_mag;
  logic signed [11:0] err_c;
  logic signed [12:0] derr_c;
  logic signed [23:0] sum_c;
  logic signed [23:0] corr_full;
  logic signed [AW-1:0] corr_c;
  logic signed [AW-1:0] cand_l;
  logic signed [AW-1:0] cand_r;

  function automatic logic [PWM_BITS-1:0] clamp_duty(input logic signed [AW-1:0] v);
    if (v[AW-1])         return '0;
    else if (v > DMAX_A) return DMAX_V;
    else                 return v[PWM_BITS-1:0];
  endfunction

  assign tick    = (cnt_q == DMAX_V);
  assign found   = line_valid && !line_lost;
  assign err_raw = $signed({1'b0, centroid_x}) - CENTER_V;
  assign err_mag = err_raw[11] ? -err_raw : err_raw;
  assign err_c   = (DB_EN && (err_mag <= DEADBAND_V)) ? '0 : err_raw;
  assign derr_c  = $signed({err_c[11], err_c}) - $signed({prev_err_q[11], prev_err_q});

  assign sum_c     = kp_term_q + kd_term_q;
  assign corr_full = sum_c >>> SHIFT;

  always_comb begin
    if (corr_full > SAT_HI)      corr_c = DMAX_A;
    else if (corr_full < SAT_LO) corr_c = -DMAX_A;
    else                         corr_c = corr_full[AW-1:0];
  end

  assign cand_l = BASE_V + corr_c;
  assign cand_r = BASE_V - corr_c;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    cnt_d      = cnt_q + 1'b1;
    state_d    = state_q;
    hold_d     = hold_q;
    search_d   = search_q;
    prev_err_d = prev_err_q;
    s1_vld_d   = 1'b0;
    s1_mode_d  = s1_mode_q;
    err_d      = err_q;
    derr_d     = derr_q;
    s2_vld_d   = s1_vld_q;
    s2_mode_d  = s1_mode_q;
    kp_term_d  = kp_term_q;
    kd_term_d  = kd_term_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    duty_l_d   = duty_l_q;
    duty_r_d   = duty_r_q;

    // Stage 1: sample inputs, step the FSM, form err/derr.
    if (tick && run) begin
      s1_vld_d = 1'b1;
      if (found) begin
        state_d    = ST_TRACK;
        err_d      = err_c;
        derr_d     = (state_q == ST_TRACK) ? derr_c : '0;
        prev_err_d = err_c;
      end else begin
        case (state_q)
          ST_TRACK: begin
            state_d = ST_COAST;
            hold_d  = CW'(1);
          end
          ST_COAST: begin
            if (hold_q == LOST_HOLD_V) begin
              state_d  = ST_SEARCH;
              search_d = CW'(1);
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          ST_SEARCH: begin
            if (search_q == SEARCH_TICKS_V) state_d = ST_STOP;
            else                            search_d = search_q + 1'b1;
          end
          default: state_d = ST_STOP;
        endcase
      end
      s1_mode_d = state_d;
    end

    if (s1_vld_q) begin
      kp_term_d = KP_V * $signed({{12{err_q[11]}}, err_q});
      kd_term_d = KD_V * $signed({{11{derr_q[12]}}, derr_q});
    end

    // Stage 3: pending duties; COAST leaves them untouched.
    if (s2_vld_q) begin
      case (s2_mode_q)
        ST_TRACK: begin
          pend_l_d = clamp_duty(cand_l);
          pend_r_d = clamp_duty(cand_r);
        end
        ST_SEARCH: begin
          pend_l_d = prev_err_q[11] ? '0 : SEARCH_V;
          pend_r_d = prev_err_q[11] ? SEARCH_V : '0;
        end
        ST_STOP: begin
          pend_l_d = '0;
          pend_r_d = '0;
        end
        default: ;
      endcase
    end

    if (tick) begin
      duty_l_d = pend_l_q;
      duty_r_d = pend_r_q;
    end

    if (!run) begin
      state_d  = ST_STOP;
      hold_d   = '0;
      search_d = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
      pend_l_d = '0;
      pend_r_d = '0;
      duty_l_d = '0;
      duty_r_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      cnt_q      <= '0;
      state_q    <= ST_STOP;
      hold_q     <= '0;
      search_q   <= '0;
      prev_err_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_mode_q  <= ST_STOP;
      err_q      <= '0;
      derr_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_mode_q  <= ST_STOP;
      kp_term_q  <= '0;
      kd_term_q  <= '0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      duty_l_q   <= '0;
      duty_r_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      search_q   <= search_d;
      prev_err_q <= prev_err_d;
      s1_vld_q   <= s1_vld_d;
      s1_mode_q  <= s1_mode_d;
      err_q      <= err_d;
      derr_q     <= derr_d;
      s2_vld_q   <= s2_vld_d;
      s2_mode_q  <= s2_mode_d;
      kp_term_q  <= kp_term_d;
      kd_term_q  <= kd_term_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      duty_l_q   <= duty_l_d;
      duty_r_q   <= duty_r_d;
    end
  end

  assign pwm_left    = run && (cnt_q < duty_l_q);
  assign pwm_right   = run && (cnt_q < duty_r_q);
  assign duty_left   = duty_l_q;
  assign duty_right  = duty_r_q;
  assign steer_state = state_q;
  assign ctrl_tick   = tick;

endmodule

// File: tb/tb_line_steer_pwm.sv
// Scoreboard bench for line_steer_pwm: a behavioural model pushes expected duties at each
// control tick; they are popped and compared when the DUT applies them one period later.
`timescale 1ns/1ps
module tb_line_steer_pwm;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [10:0] centroid_x;
  logic        line_valid;
  logic        line_lost;
  logic        pwm_left;
  logic        pwm_right;
  logic [7:0]  duty_left;
  logic [7:0]  duty_right;
  logic [1:0]  steer_state;
  logic        ctrl_tick;

  always #5 clk = ~clk;

  line_steer_pwm dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .centroid_x (centroid_x),
    .line_valid (line_valid),
    .line_lost  (line_lost),
    .pwm_left   (pwm_left),
    .pwm_right  (pwm_right),
    .duty_left  (duty_left),
    .duty_right (duty_right),
    .steer_state(steer_state),
    .ctrl_tick  (ctrl_tick)
  );

  typedef struct {
    int l;
    int r;
    int st;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_state, m_prev, m_hold, m_search, m_pl, m_pr;
  int cur_l, cur_r;
  bit aligned;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_tick(input int cx, input bit v, input bit l);
    int  err, derr, sum, corr;
    bit  entry;
    exp_t e;
    if (v && !l) begin
      entry = (m_state != 1);
      err   = cx - 320;
`ifdef STEER_DEADBAND_EN
      if (err <= 4 && err >= -4) err = 0;
`endif
      derr   = entry ? 0 : err - m_prev;
      m_prev = err;
      sum    = 4 * err + 2 * derr;
      corr   = sum >>> 2;
      if (corr > 255)  corr = 255;
      if (corr < -255) corr = -255;
      m_pl    = clamp(128 + corr);
      m_pr    = clamp(128 - corr);
      m_state = 1;
    end else begin
      case (m_state)
        1: begin m_state = 2; m_hold = 1; end
        2: if (m_hold == 4) begin m_state = 3; m_search = 1; end else m_hold++;
        3: if (m_search == 64) m_state = 0; else m_search++;
        default: m_state = 0;
      endcase
      if (m_state == 3) begin
        m_pl = (m_prev < 0) ? 0 : 96;
        m_pr = (m_prev < 0) ? 96 : 0;
      end else if (m_state == 0) begin
        m_pl = 0;
        m_pr = 0;
      end
    end
    e.l = m_pl; e.r = m_pr; e.st = m_state;
    sb_q.push_back(e);
  endtask

  task automatic flush_model(input bit keep_prev);
    exp_t e;
    sb_q.delete();
    m_state = 0; m_hold = 0; m_search = 0; m_pl = 0; m_pr = 0;
    if (!keep_prev) m_prev = 0;
    e.l = 0; e.r = 0; e.st = 0;
    sb_q.push_back(e);
    cur_l = 0; cur_r = 0;
    aligned = 1'b0;
  endtask

  // One control period: garbage inputs early (must be ignored), real inputs before the tick.
  task automatic period(input int cx, input bit v, input bit l);
    int   n, hl, hr;
    exp_t e;
    n = 0; hl = 0; hr = 0;
    if (aligned) begin
      centroid_x = 11'($urandom_range(0, 2047));
      line_valid = 1'($urandom);
      line_lost  = 1'($urandom);
      repeat (40) begin
        @(negedge clk);
        n++; hl += int'(pwm_left); hr += int'(pwm_right);
      end
    end
    centroid_x = 11'(cx);
    line_valid = v;
    line_lost  = l;
    while (1) begin
      @(negedge clk);
      n++; hl += int'(pwm_left); hr += int'(pwm_right);
      if (ctrl_tick) break;
      if (n > 300) begin
        check("tick_timeout", n, 256);
        break;
      end
    end
    if (aligned) begin
      check("period_len", n, 256);
      check("pwm_l_high", hl, cur_l);
      check("pwm_r_high", hr, cur_r);
    end
    model_tick(cx, v, l);
    @(posedge clk); #1;
    check("state", int'(steer_state), sb_q[$].st);
    if (sb_q.size() > 1) begin
      e = sb_q.pop_front();
      check("duty_l", int'(duty_left), e.l);
      check("duty_r", int'(duty_right), e.r);
      cur_l = e.l;
      cur_r = e.r;
    end
    aligned = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b1; centroid_x = '0; line_valid = 1'b0; line_lost = 1'b0;
    m_prev = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_duty_l", int'(duty_left), 0);
    check("rst_duty_r", int'(duty_right), 0);
    check("rst_state", int'(steer_state), 0);
    check("rst_pwm_l", int'(pwm_left), 0);
    check("rst_pwm_r", int'(pwm_right), 0);
    check("rst_tick", int'(ctrl_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    flush_model(1'b0);

    repeat (3) period(400, 1'b1, 1'b0);
    repeat (2) period(360, 1'b1, 1'b0);
    repeat (3) period(639, 1'b1, 1'b0);
    repeat (2) period(2000, 1'b1, 1'b0);
    repeat (3) period(400, 1'b1, 1'b0);
    period(400, 1'b1, 1'b1);
    repeat (70) period(0, 1'b0, 1'b0);
    repeat (2) period(320, 1'b1, 1'b0);
    repeat (2) period(323, 1'b1, 1'b0);
    repeat (2) period(200, 1'b1, 1'b0);
    repeat (7) period(200, 1'b0, 1'b1);
    repeat (2) period(360, 1'b1, 1'b0);

    // Drop run mid-period; found inputs while stopped must not leave STOP.
    repeat (100) @(negedge clk);
    check("pwm_l_pre_drop", int'(pwm_left), (99 < cur_l) ? 1 : 0);
    run = 1'b0;
    @(posedge clk); #1;
    check("drop_pwm_l", int'(pwm_left), 0);
    check("drop_pwm_r", int'(pwm_right), 0);
    check("drop_state", int'(steer_state), 0);
    check("drop_duty_l", int'(duty_left), 0);
    check("drop_duty_r", int'(duty_right), 0);
    centroid_x = 11'd400; line_valid = 1'b1; line_lost = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (ctrl_tick) break;
      if (n > 300) begin
        check("stop_tick_timeout", n, 256);
        break;
      end
    end
    @(posedge clk); #1;
    check("stop_hold_state", int'(steer_state), 0);
    @(negedge clk);
    run = 1'b1;
    flush_model(1'b1);
    repeat (3) period(400, 1'b1, 1'b0);

    // Synchronous reset mid-period.
    repeat (100) @(negedge clk);
    check("pwm_l_pre_rst", int'(pwm_left), (99 < cur_l) ? 1 : 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_pwm_l", int'(pwm_left), 0);
    check("mrst_pwm_r", int'(pwm_right), 0);
    check("mrst_duty_l", int'(duty_left), 0);
    check("mrst_duty_r", int'(duty_right), 0);
    check("mrst_state", int'(steer_state), 0);
    check("mrst_tick", int'(ctrl_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    flush_model(1'b0);
    repeat (3) period(400, 1'b1, 1'b0);
    repeat (2) period(360, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
